ex_mem_skid: RTL and testbench

Two-entry skid buffer forming the EX/MEM pipeline boundary directly downstream of the 129-bit ALU. It captures the ALU result (bit 128 is the capability tag, bits 127:0 the capability/integer payload), the zero flag, and the memory/writeback controls. It holds them under a valid/ready handshake so that memory-stage stalls do not combinationally reach the execute stage. It also keeps a memory-stall cycle counter for the capability-width CPI study.

---
 rtl/ex_mem_skid.sv | 109 ++++++++++
 tb/tb_ex_mem_skid.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_skid.sv
// EX/MEM two-entry skid buffer with a registered in_ready and a memory-stall cycle counter.
// Optional macro CAP_TAG_CLEAR_EN: clear result tag bit W-1 on capture of integer (in_capop=0) ops.
module ex_mem_skid #(
  parameter int W     = 129,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_result,
  input  logic             in_zero,
  input  logic [4:0]       in_rd,
  input  logic             in_regwrite,
  input  logic             in_memread,
  input  logic             in_memwrite,
  input  logic             in_capop,
  input  logic [W-1:0]     in_store_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_result,
  output logic             out_zero,
  output logic [4:0]       out_rd,
  output logic             out_regwrite,
  output logic             out_memread,
  output logic             out_memwrite,
  output logic [W-1:0]     out_store_data,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int BW = 2 * W + 9;

  logic             m_valid_q, m_valid_d;
  logic             s_valid_q, s_valid_d;
  logic [BW-1:0]    m_q, m_d;
  logic [BW-1:0]    s_q, s_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [W-1:0]     result_eff;
  logic [BW-1:0]    in_bundle;
  logic             in_fire;
  logic             out_fire;

  always_comb begin
    result_eff = in_result;
`ifdef CAP_TAG_CLEAR_EN
    if (!in_capop) result_eff[W-1] = 1'b0;
`else
    result_eff = in_result ^ {W{1'b0 & in_capop}};
`endif
  end

  assign in_bundle = {result_eff, in_zero, in_rd, in_regwrite, in_memread,
                      in_memwrite, in_store_data};

  // in_ready depends only on the skid valid flop, never on out_ready.
  assign in_ready = !s_valid_q;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = m_valid_q & out_ready;

  always_comb begin
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    m_d       = m_q;
    s_d       = s_q;
    stall_d   = stall_q + CNT_W'(m_valid_q & !out_ready);
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (!m_valid_q || out_fire) begin
      if (s_valid_q) begin
        m_valid_d = 1'b1;
        m_d       = s_q;
        s_valid_d = in_fire;
        if (in_fire) s_d = in_bundle;
      end else if (in_fire) begin
        m_valid_d = 1'b1;
        m_d       = in_bundle;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      s_valid_d = 1'b1;
      s_d       = in_bundle;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      m_q       <= '0;
      s_q       <= '0;
      stall_q   <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      m_q       <= m_d;
      s_q       <= s_d;
      stall_q   <= stall_d;
    end
  end

  assign out_valid    = m_valid_q;
  assign stall_cycles = stall_q;
  assign {out_result, out_zero, out_rd, out_regwrite, out_memread,
          out_memwrite, out_store_data} = m_q;

endmodule

// File: tb/tb_ex_mem_skid.sv
// Directed table-driven bench for ex_mem_skid plus hand sequences for tag, reset and counter wrap.
module tb_ex_mem_skid;
  localparam int W = 129;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, in_zero, in_regwrite, in_memread, in_memwrite, in_capop;
  logic [W-1:0] in_result, in_store_data;
  logic [4:0]   in_rd;
  logic         flush, out_valid, out_ready;
  logic [W-1:0] out_result, out_store_data;
  logic         out_zero, out_regwrite, out_memread, out_memwrite;
  logic [4:0]   out_rd;
  logic [31:0]  stall_cycles;

  logic         w4_in_valid, w4_in_ready, w4_out_valid, w4_out_ready;
  logic [W-1:0] w4_out_result, w4_out_store_data;
  logic         w4_out_zero, w4_out_regwrite, w4_out_memread, w4_out_memwrite;
  logic [4:0]   w4_out_rd;
  logic [3:0]   w4_stall;

  ex_mem_skid #(.W(W), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_zero(in_zero), .in_rd(in_rd),
    .in_regwrite(in_regwrite), .in_memread(in_memread), .in_memwrite(in_memwrite),
    .in_capop(in_capop), .in_store_data(in_store_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_rd(out_rd), .out_regwrite(out_regwrite),
    .out_memread(out_memread), .out_memwrite(out_memwrite),
    .out_store_data(out_store_data), .stall_cycles(stall_cycles)
  );

  ex_mem_skid #(.W(W), .CNT_W(4)) dut_w4 (
    .clk(clk), .rst(rst), .in_valid(w4_in_valid), .in_ready(w4_in_ready),
    .in_result('0), .in_zero(1'b0), .in_rd(5'd0),
    .in_regwrite(1'b0), .in_memread(1'b0), .in_memwrite(1'b0),
    .in_capop(1'b1), .in_store_data('0), .flush(1'b0),
    .out_valid(w4_out_valid), .out_ready(w4_out_ready), .out_result(w4_out_result),
    .out_zero(w4_out_zero), .out_rd(w4_out_rd), .out_regwrite(w4_out_regwrite),
    .out_memread(w4_out_memread), .out_memwrite(w4_out_memwrite),
    .out_store_data(w4_out_store_data), .stall_cycles(w4_stall)
  );

  typedef struct {
    logic        iv;
    logic [7:0]  id;
    logic        ordy;
    logic        fl;
    logic        ov;
    logic        ir;
    logic [7:0]  eid;
    logic [31:0] est;
  } vec_t;

  vec_t vecs[19];
  int   checks = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [W-1:0] res_of(input logic [7:0] id);
    return {1'b1, 120'h0, id};
  endfunction

  function automatic logic [W-1:0] sd_of(input logic [7:0] id);
    return {121'h0, id ^ 8'hA5};
  endfunction

  task automatic drive_id(input logic iv, input logic [7:0] id);
    in_valid      = iv;
    in_result     = res_of(id);
    in_zero       = id[0];
    in_rd         = id[4:0];
    in_regwrite   = id[1];
    in_memread    = id[2];
    in_memwrite   = id[3];
    in_capop      = 1'b1;
    in_store_data = sd_of(id);
  endtask

  task automatic check_bundle(input string tag, input logic [7:0] id);
    check({tag, ".result"}, out_result, res_of(id));
    check({tag, ".rd"}, W'(out_rd), W'(id[4:0]));
    check({tag, ".ctl"}, W'({out_zero, out_regwrite, out_memread, out_memwrite}),
          W'({id[0], id[1], id[2], id[3]}));
    check({tag, ".store"}, out_store_data, sd_of(id));
  endtask

  initial begin
    // Single bundle, 4-cycle back-pressure on 1..6 with refill from skid, then flush cases.
    vecs[0]  = '{1'b1, 8'd5,  1'b1, 1'b0, 1'b1, 1'b1, 8'd5,  32'd0};
    vecs[1]  = '{1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 1'b1, 8'd0,  32'd0};
    vecs[2]  = '{1'b1, 8'd1,  1'b1, 1'b0, 1'b1, 1'b1, 8'd1,  32'd0};
    vecs[3]  = '{1'b1, 8'd2,  1'b0, 1'b0, 1'b1, 1'b0, 8'd1,  32'd1};
    vecs[4]  = '{1'b1, 8'd3,  1'b0, 1'b0, 1'b1, 1'b0, 8'd1,  32'd2};
    vecs[5]  = '{1'b1, 8'd3,  1'b0, 1'b0, 1'b1, 1'b0, 8'd1,  32'd3};
    vecs[6]  = '{1'b1, 8'd3,  1'b0, 1'b0, 1'b1, 1'b0, 8'd1,  32'd4};
    vecs[7]  = '{1'b1, 8'd3,  1'b1, 1'b0, 1'b1, 1'b1, 8'd2,  32'd4};
    vecs[8]  = '{1'b1, 8'd3,  1'b1, 1'b0, 1'b1, 1'b1, 8'd3,  32'd4};
    vecs[9]  = '{1'b1, 8'd4,  1'b1, 1'b0, 1'b1, 1'b1, 8'd4,  32'd4};
    vecs[10] = '{1'b1, 8'd5,  1'b1, 1'b0, 1'b1, 1'b1, 8'd5,  32'd4};
    vecs[11] = '{1'b1, 8'd6,  1'b1, 1'b0, 1'b1, 1'b1, 8'd6,  32'd4};
    vecs[12] = '{1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 1'b1, 8'd0,  32'd4};
    vecs[13] = '{1'b1, 8'd10, 1'b0, 1'b0, 1'b1, 1'b1, 8'd10, 32'd4};
    vecs[14] = '{1'b1, 8'd11, 1'b0, 1'b0, 1'b1, 1'b0, 8'd10, 32'd5};
    vecs[15] = '{1'b1, 8'd12, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0,  32'd5};
    vecs[16] = '{1'b1, 8'd13, 1'b0, 1'b0, 1'b1, 1'b1, 8'd13, 32'd5};
    vecs[17] = '{1'b1, 8'd14, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0,  32'd5};
    vecs[18] = '{1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 1'b1, 8'd0,  32'd5};

    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    w4_in_valid = 1'b0; w4_out_ready = 1'b1;
    drive_id(1'b0, 8'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset.out_valid", W'(out_valid), W'(0));
    check("reset.in_ready", W'(in_ready), W'(1));
    check("reset.stall", W'(stall_cycles), W'(0));
    check("reset.result", out_result, '0);
    check("reset.store", out_store_data, '0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      drive_id(vecs[i].iv, vecs[i].id);
      out_ready = vecs[i].ordy;
      flush     = vecs[i].fl;
      @(posedge clk);
      #1;
      check($sformatf("v%0d.out_valid", i), W'(out_valid), W'(vecs[i].ov));
      check($sformatf("v%0d.in_ready", i), W'(in_ready), W'(vecs[i].ir));
      check($sformatf("v%0d.stall", i), W'(stall_cycles), W'(vecs[i].est));
      if (vecs[i].ov) check_bundle($sformatf("v%0d", i), vecs[i].eid);
    end

    // Integer op with tag bit set, then a capability op with the same tag.
    @(negedge clk);
    drive_id(1'b1, 8'd0);
    flush = 1'b0; out_ready = 1'b1;
    in_capop  = 1'b0;
    in_result = {1'b1, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210};
    @(posedge clk);
    #1;
`ifdef CAP_TAG_CLEAR_EN
    check("tag.int.bit128", W'(out_result[W-1]), W'(0));
`else
    check("tag.int.bit128", W'(out_result[W-1]), W'(1));
`endif
    check("tag.int.low", W'(out_result[W-2:0]), W'(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210));
    @(negedge clk);
    in_capop = 1'b1;
    @(posedge clk);
    #1;
    check("tag.cap.bit128", W'(out_result[W-1]), W'(1));

    // Fill both entries, then rst together with flush clears everything.
    @(negedge clk);
    drive_id(1'b1, 8'd20);
    out_ready = 1'b0;
    @(negedge clk);
    drive_id(1'b1, 8'd21);
    @(negedge clk);
    check("fill.in_ready", W'(in_ready), W'(0));
    rst = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    check("rst.out_valid", W'(out_valid), W'(0));
    check("rst.in_ready", W'(in_ready), W'(1));
    check("rst.stall", W'(stall_cycles), W'(0));
    check("rst.rd", W'(out_rd), W'(0));
    @(negedge clk);
    rst = 1'b0; flush = 1'b0;
    drive_id(1'b0, 8'd0);

    // Narrow counter: 17 stall cycles wrap a 4-bit counter to 1.
    w4_in_valid = 1'b1; w4_out_ready = 1'b0;
    @(posedge clk);
    #1;
    check("w4.load", W'(w4_out_valid), W'(1));
    check("w4.zero", W'(w4_stall), W'(0));
    @(negedge clk);
    w4_in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("w4.at15", W'(w4_stall), W'(15));
    @(posedge clk);
    #1;
    check("w4.at16", W'(w4_stall), W'(0));
    @(posedge clk);
    #1;
    check("w4.at17", W'(w4_stall), W'(1));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
